// File: rtl/tiny_rv_pkg.sv
// Shared decode definitions for the tiny_rv pipeline: opcode and funct
// encodings, the immediate-format selector and the registered decode bundle.
package tiny_rv_pkg;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_ALU    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // ALU funct3
    localparam logic [2:0] F3_ADD = 3'd0;
    localparam logic [2:0] F3_SHL = 3'd1;
    localparam logic [2:0] F3_SHR = 3'd5;

    // BRANCH funct3 (2 and 3 are unassigned)
    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;

    // LOAD funct3 (3, 6 and 7 are unassigned)
    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    // STORE funct3 (anything above SW is unassigned)
    localparam logic [2:0] F3_SB = 3'd0;
    localparam logic [2:0] F3_SH = 3'd1;
    localparam logic [2:0] F3_SW = 3'd2;

    // funct7 values
    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_fmt_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
        logic [31:0] imm;
        logic        rd_we;
        logic        illegal;
    } decode_bundle_t;

endpackage

// File: rtl/tiny_rv_imm_gen.sv
// Combinational immediate generator: selects and sign-extends the immediate
// for the given instruction format. IMM_NONE yields zero (R format, illegal).
module tiny_rv_imm_gen
    import tiny_rv_pkg::*;
(
    input  logic [31:7] instr,
    input  imm_fmt_e    fmt,
    output logic [31:0] imm
);

    // Assemble the immediate for the selected format
    always_comb begin
        // NOTE: assign a default first so every path drives imm and no latch is inferred.
        imm = '0;
        case (fmt)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/tiny_rv_decode_stage.sv
// Registered decode stage between fetch and execute. Decodes a fetched
// {pc, instr} into the bundle consumed by the ALU / branch / LSU units.
// Build option: TINY_RV_DECODE_SKID_EN adds a one-entry skid buffer so that
// o_ready comes straight from a flop instead of from i_ready.
module tiny_rv_decode_stage
    import tiny_rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_flush,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_instr,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_pc,
    output logic [6:0]  o_opcode,
    output logic [2:0]  o_funct3,
    output logic [6:0]  o_funct7,
    output logic [4:0]  o_rs1_addr,
    output logic [4:0]  o_rs2_addr,
    output logic [4:0]  o_rd_addr,
    output logic [31:0] o_imm,
    output logic        o_rd_we,
    output logic        o_illegal
);

    localparam decode_bundle_t RESET_BUNDLE = '{
        pc: RESET_PC, opcode: 7'd0, funct3: 3'd0, funct7: 7'd0,
        rs1_addr: 5'd0, rs2_addr: 5'd0, rd_addr: 5'd0,
        imm: 32'd0, rd_we: 1'b0, illegal: 1'b0
    };

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = i_instr[6:0];
    assign funct3 = i_instr[14:12];
    assign funct7 = i_instr[31:25];

    imm_fmt_e       imm_fmt;
    imm_fmt_e       gen_fmt;
    logic           has_rs1;
    logic           has_rs2;
    logic           has_rd;
    logic           writes_rd;
    logic           illegal;
    logic [31:0]    imm_value;
    decode_bundle_t dec;

    // Classify the opcode: format, which register fields are meaningful, legality
    always_comb begin
        imm_fmt   = IMM_NONE;
        has_rs1   = 1'b1;
        has_rs2   = 1'b0;
        has_rd    = 1'b1;
        writes_rd = 1'b0;
        illegal   = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC: begin
                imm_fmt   = IMM_U;
                has_rs1   = 1'b0;
                writes_rd = 1'b1;
            end
            OP_JAL: begin
                imm_fmt   = IMM_J;
                has_rs1   = 1'b0;
                writes_rd = 1'b1;
            end
            OP_JALR: begin
                imm_fmt   = IMM_I;
                writes_rd = 1'b1;
            end
            OP_BRANCH: begin
                imm_fmt = IMM_B;
                has_rs2 = 1'b1;
                has_rd  = 1'b0;
                illegal = (funct3 == 3'd2) || (funct3 == 3'd3);
            end
            OP_LOAD: begin
                imm_fmt   = IMM_I;
                writes_rd = 1'b1;
                illegal   = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
            end
            OP_STORE: begin
                imm_fmt = IMM_S;
                has_rs2 = 1'b1;
                has_rd  = 1'b0;
                illegal = (funct3 > F3_SW);
            end
            OP_ALUI: begin
                imm_fmt   = IMM_I;
                writes_rd = 1'b1;
                if (funct3 == F3_SHL) begin
                    illegal = (funct7 != F7_BASE);
                end else if (funct3 == F3_SHR) begin
                    illegal = (funct7 != F7_BASE) && (funct7 != F7_ALT);
                end
            end
            OP_ALU: begin
                imm_fmt   = IMM_NONE;
                has_rs2   = 1'b1;
                writes_rd = 1'b1;
                illegal   = !((funct7 == F7_BASE) ||
                              ((funct7 == F7_ALT) && ((funct3 == F3_ADD) || (funct3 == F3_SHR))));
            end
            OP_FENCE: begin
                imm_fmt = IMM_I;
            end
            OP_SYSTEM: begin
                imm_fmt   = IMM_I;
                writes_rd = 1'b1;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
        // Compressed / non-32-bit encodings are never decodable here
        if (i_instr[1:0] != 2'b11) begin
            illegal = 1'b1;
        end
    end

    // An illegal word carries no immediate
    assign gen_fmt = illegal ? IMM_NONE : imm_fmt;

    tiny_rv_imm_gen u_imm_gen (
        .instr (i_instr[31:7]),
        .fmt   (gen_fmt),
        .imm   (imm_value)
    );

    // Build the decoded bundle; illegal words pass their raw register fields through
    always_comb begin
        dec          = '0;
        dec.pc       = i_pc;
        dec.opcode   = opcode;
        dec.funct3   = funct3;
        dec.funct7   = funct7;
        dec.rs1_addr = (illegal || has_rs1) ? i_instr[19:15] : 5'd0;
        dec.rs2_addr = (illegal || has_rs2) ? i_instr[24:20] : 5'd0;
        dec.rd_addr  = (illegal || has_rd)  ? i_instr[11:7]  : 5'd0;
        dec.imm      = imm_value;
        dec.rd_we    = !illegal && writes_rd && (i_instr[11:7] != 5'd0);
        dec.illegal  = illegal;
    end

    decode_bundle_t out_q;
    logic           out_valid;
    logic           in_xfer;

    assign in_xfer = i_valid && o_ready;

`ifdef TINY_RV_DECODE_SKID_EN
    decode_bundle_t skid_q;
    logic           skid_valid;

    // Ready is simply "skid empty", a registered signal
    assign o_ready = !skid_valid;

    // Output register and skid occupancy; flush empties both
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!i_rst_n) begin
            out_q      <= RESET_BUNDLE;
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (i_flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!out_valid || i_ready) begin
            if (skid_valid) begin
                out_q      <= skid_q;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else if (in_xfer) begin
                out_q     <= dec;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (in_xfer) begin
            skid_valid <= 1'b1;
        end
    end

    // Capture a word accepted while the output is stalled
    always_ff @(posedge i_clk) begin
        // NOTE: skid data needs no reset; skid_valid alone says whether it is meaningful.
        if (in_xfer && out_valid && !i_ready) begin
            skid_q <= dec;
        end
    end
`else
    // Accept whenever the output register is empty or being drained
    assign o_ready = !out_valid || i_ready;

    // Output register: load on transfer in, clear valid on transfer out, flush wins
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!i_rst_n) begin
            out_q     <= RESET_BUNDLE;
            out_valid <= 1'b0;
        end else if (i_flush) begin
            out_valid <= 1'b0;
        end else if (in_xfer) begin
            out_q     <= dec;
            out_valid <= 1'b1;
        end else if (i_ready) begin
            out_valid <= 1'b0;
        end
    end
`endif

    assign o_valid    = out_valid;
    assign o_pc       = out_q.pc;
    assign o_opcode   = out_q.opcode;
    assign o_funct3   = out_q.funct3;
    assign o_funct7   = out_q.funct7;
    assign o_rs1_addr = out_q.rs1_addr;
    assign o_rs2_addr = out_q.rs2_addr;
    assign o_rd_addr  = out_q.rd_addr;
    assign o_imm      = out_q.imm;
    assign o_rd_we    = out_q.rd_we;
    assign o_illegal  = out_q.illegal;

endmodule
